// File: rtl/hk_mash_ncl.sv
// HK-MASH 1-1-1 noise-cancellation and output combiner.
// Forms n_int + y1 + (1-z^-1)y2 + (1-z^-1)^2 y3, saturated to the divider range.
module hk_mash_ncl #(
    parameter int INT_W   = 8,
    parameter bit ALIGN   = 1'b0,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             y1_i,
    input  logic             y2_i,
    input  logic             y3_i,
    input  logic [INT_W-1:0] n_int_i,
    input  logic             n_load_i,
    output logic [INT_W-1:0] div_o,
    output logic [3:0]       c_o,
    output logic             valid_o,
    output logic             range_err_o
);

    localparam int          SW     = INT_W + 2;
    localparam logic [2:0]  WU_MAX = 3'(2 + 2 * int'(ALIGN));

    logic y1a, y2a, y3a;

    generate
        if (ALIGN) begin : g_align
            logic y1_d1, y1_d2, y2_d1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y1_d1 <= 1'b0;
                    y1_d2 <= 1'b0;
                    y2_d1 <= 1'b0;
                end else if (en_i) begin
                    y1_d1 <= y1_i;
                    y1_d2 <= y1_d1;
                    y2_d1 <= y2_i;
                end
            end

            assign y1a = y1_d2;
            assign y2a = y2_d1;
            assign y3a = y3_i;
        end else begin : g_direct
            assign y1a = y1_i;
            assign y2a = y2_i;
            assign y3a = y3_i;
        end
    endgenerate

    logic             y2p, y3p1, y3p2;
    logic [INT_W-1:0] n_int_r;
    logic [2:0]       wu_cnt;
    logic             wu_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y2p    <= 1'b0;
            y3p1   <= 1'b0;
            y3p2   <= 1'b0;
            wu_cnt <= 3'd0;
        end else if (en_i) begin
            y2p  <= y2a;
            y3p1 <= y3a;
            y3p2 <= y3p1;
            if (!wu_full) begin
                wu_cnt <= wu_cnt + 3'd1;
            end
        end
    end

    // A load lands after the edge, so the sample taken on that edge sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_int_r <= '0;
        end else if (n_load_i) begin
            n_int_r <= n_int_i;
        end
    end

    assign wu_full = (wu_cnt == WU_MAX);

    logic signed [3:0]    c;
    logic signed [SW-1:0] s;
    logic [INT_W-1:0]     div_n;
    logic                 err_n;
    logic                 valid_n;

    // Every partial sum stays within -3..+4, so 4-bit signed never wraps.
    always_comb begin
        c = $signed({3'b000, y1a})
          + $signed({3'b000, y2a})
          - $signed({3'b000, y2p})
          + $signed({3'b000, y3a})
          - $signed({2'b00, y3p1, 1'b0})
          + $signed({3'b000, y3p2});
    end

    always_comb begin
        s       = $signed({2'b00, n_int_r}) + {{(SW-4){c[3]}}, c};
        div_n   = s[INT_W-1:0];
        err_n   = 1'b0;
        valid_n = en_i & wu_full;
        if (s[SW-1]) begin
            div_n = '0;
            err_n = 1'b1;
        end else if (s[INT_W]) begin
            div_n = '1;
            err_n = 1'b1;
        end
    end

    generate
        if (OUT_REG) begin : g_oreg
            logic [INT_W-1:0] div_q;
            logic [3:0]       c_q;
            logic             err_q;
            logic             valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    div_q   <= '0;
                    c_q     <= 4'd0;
                    err_q   <= 1'b0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= valid_n;
                    if (en_i) begin
                        div_q <= div_n;
                        c_q   <= c;
                        err_q <= err_n;
                    end
                end
            end

            assign div_o       = div_q;
            assign c_o         = c_q;
            assign range_err_o = err_q;
            assign valid_o     = valid_q;
        end else begin : g_ocomb
            assign div_o       = rst ? '0 : div_n;
            assign c_o         = rst ? 4'd0 : c;
            assign range_err_o = rst ? 1'b0 : err_n;
            assign valid_o     = rst ? 1'b0 : valid_n;
        end
    endgenerate

endmodule

// File: tb/tb_hk_mash_ncl.sv
// Directed bench for hk_mash_ncl.
// Runs an ALIGN=0 and an ALIGN=1 instance side by side.
module tb_hk_mash_ncl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       y1  = 1'b0;
    logic       y2  = 1'b0;
    logic       y3  = 1'b0;
    logic       ya2 = 1'b0;
    logic       ya3 = 1'b0;
    logic       ld  = 1'b0;
    logic [7:0] n   = 8'd0;

    logic [7:0] div0, div1;
    logic [3:0] c0, c1;
    logic       v0, v1, e0, e1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hk_mash_ncl #(.INT_W(8), .ALIGN(1'b0), .OUT_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .en_i(en),
        .y1_i(y1), .y2_i(y2), .y3_i(y3),
        .n_int_i(n), .n_load_i(ld),
        .div_o(div0), .c_o(c0), .valid_o(v0), .range_err_o(e0)
    );

    hk_mash_ncl #(.INT_W(8), .ALIGN(1'b1), .OUT_REG(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en_i(en),
        .y1_i(y1), .y2_i(ya2), .y3_i(ya3),
        .n_int_i(n), .n_load_i(ld),
        .div_o(div1), .c_o(c1), .valid_o(v1), .range_err_o(e1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        en = 1'b0;
        ld = 1'b1;
        n  = v;
        tick();
        ld = 1'b0;
    endtask

    task automatic sample(input logic a, input logic b, input logic d);
        en = 1'b1;
        y1 = a;
        y2 = b;
        y3 = d;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({div0, c0, v0, e0} !== 14'd0) begin
            errors++;
            $display("FAIL reset0 got div=%0d c=%0d v=%b e=%b want all 0", div0, c0, v0, e0);
        end
        checks++;
        if ({div1, c1, v1, e1} !== 14'd0) begin
            errors++;
            $display("FAIL reset1 got div=%0d c=%0d v=%b e=%b want all 0", div1, c1, v1, e1);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        load(8'd100);
        for (int i = 0; i < 10; i++) begin
            logic ev;
            ev = (i >= 2);
            sample(1'b0, 1'b0, 1'b0);
            checks++;
            if (div0 !== 8'd100 || c0 !== 4'd0) begin
                errors++;
                $display("FAIL zero[%0d] got div=%0d c=%0d want 100 0", i, div0, c0);
            end
            checks++;
            if (v0 !== ev) begin
                errors++;
                $display("FAIL zero_valid[%0d] got %b want %b", i, v0, ev);
            end
        end
    endtask

    task automatic test_stage1();
        for (int i = 0; i < 4; i++) begin
            sample(1'b1, 1'b0, 1'b0);
            checks++;
            if (div0 !== 8'd101 || c0 !== 4'd1 || v0 !== 1'b1 || e0 !== 1'b0) begin
                errors++;
                $display("FAIL stage1[%0d] got div=%0d c=%0d v=%b e=%b want 101 1 1 0",
                         i, div0, c0, v0, e0);
            end
        end
    endtask

    task automatic test_impulse();
        int   ec [4];
        int   ed [4];
        logic ys [4];
        ec = '{1, -2, 1, 0};
        ed = '{51, 48, 51, 50};
        ys = '{1'b1, 1'b0, 1'b0, 1'b0};
        load(8'd50);
        for (int i = 0; i < 4; i++) begin
            sample(1'b0, 1'b0, ys[i]);
            checks++;
            if (c0 !== 4'(ec[i]) || div0 !== 8'(ed[i])) begin
                errors++;
                $display("FAIL impulse[%0d] got c=%0d div=%0d want %0d %0d",
                         i, $signed(c0), div0, ec[i], ed[i]);
            end
        end
    endtask

    task automatic test_range();
        load(8'd1);
        sample(1'b0, 1'b1, 1'b1);
        checks++;
        if (c0 !== 4'd2 || div0 !== 8'd3 || e0 !== 1'b0) begin
            errors++;
            $display("FAIL range_pre got c=%0d div=%0d e=%b want 2 3 0", $signed(c0), div0, e0);
        end
        sample(1'b0, 1'b0, 1'b0);
        checks++;
        if (c0 !== 4'(-3) || div0 !== 8'd0 || e0 !== 1'b1) begin
            errors++;
            $display("FAIL range_low got c=%0d div=%0d e=%b want -3 0 1", $signed(c0), div0, e0);
        end
        load(8'd253);
        sample(1'b1, 1'b1, 1'b1);
        checks++;
        if (c0 !== 4'd4 || div0 !== 8'd255 || e0 !== 1'b1) begin
            errors++;
            $display("FAIL range_high got c=%0d div=%0d e=%b want 4 255 1", $signed(c0), div0, e0);
        end
    endtask

    task automatic test_load_stall();
        int ed [6];
        ed = '{18, 22, 21, 21, 31, 31};
        load(8'd20);
        for (int i = 0; i < 6; i++) begin
            ld = (i == 3);
            n  = 8'd30;
            sample(1'b1, 1'b0, 1'b0);
            checks++;
            if (div0 !== 8'(ed[i])) begin
                errors++;
                $display("FAIL load[%0d] got div=%0d want %0d", i, div0, ed[i]);
            end
        end
        ld = 1'b0;
        en = 1'b0;
        y1 = 1'b0;
        y2 = 1'b1;
        y3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (div0 !== 8'd31 || c0 !== 4'd1 || v0 !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d] got div=%0d c=%0d v=%b want 31 1 0", i, div0, c0, v0);
            end
        end
        sample(1'b1, 1'b0, 1'b0);
        checks++;
        if (div0 !== 8'd31 || c0 !== 4'd1 || v0 !== 1'b1) begin
            errors++;
            $display("FAIL resume got div=%0d c=%0d v=%b want 31 1 1", div0, c0, v0);
        end
        load(8'd40);
        load(8'd35);
        sample(1'b1, 1'b0, 1'b0);
        checks++;
        if (div0 !== 8'd36) begin
            errors++;
            $display("FAIL back_to_back got div=%0d want 36", div0);
        end
    endtask

    task automatic test_align_reset();
        logic p1 [10];
        logic p2 [10];
        logic p3 [10];
        int   ec [8];
        int   ea [10];
        p1 = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        p2 = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
        p3 = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        ec = '{1, 1, 2, -2, 0, 2, -1, 0};
        ea = '{0, 0, 1, 1, 2, -2, 0, 2, -1, 0};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load(8'd50);
        for (int t = 0; t < 10; t++) begin
            logic ev;
            ya2 = (t >= 1) ? p2[t-1] : 1'b0;
            ya3 = (t >= 2) ? p3[t-2] : 1'b0;
            ev  = (t >= 4);
            sample(p1[t], p2[t], p3[t]);
            if (t < 8) begin
                checks++;
                if (c0 !== 4'(ec[t])) begin
                    errors++;
                    $display("FAIL pat0[%0d] got c=%0d want %0d", t, $signed(c0), ec[t]);
                end
            end
            checks++;
            if (c1 !== 4'(ea[t]) || div1 !== 8'(50 + ea[t]) || v1 !== ev) begin
                errors++;
                $display("FAIL pat1[%0d] got c=%0d div=%0d v=%b want %0d %0d %b",
                         t, $signed(c1), div1, v1, ea[t], 50 + ea[t], ev);
            end
        end
        ya2 = 1'b0;
        ya3 = 1'b0;
        sample(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        checks++;
        if ({div0, c0, v0, e0} !== 14'd0 || {div1, c1, v1, e1} !== 14'd0) begin
            errors++;
            $display("FAIL async_rst got div0=%0d v0=%b div1=%0d v1=%b want 0", div0, v0, div1, v1);
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic ev0, ev1;
            ev0 = (i >= 2);
            ev1 = (i >= 4);
            sample(1'b0, 1'b0, 1'b0);
            checks++;
            if (v0 !== ev0 || v1 !== ev1 || div0 !== 8'd0 || div1 !== 8'd0) begin
                errors++;
                $display("FAIL requal[%0d] got v0=%b v1=%b div0=%0d div1=%0d want %b %b 0 0",
                         i, v0, v1, div0, div1, ev0, ev1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_stage1();
        test_impulse();
        test_range();
        test_load_stall();
        test_align_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
